// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared CPU package: arbiter FSM encoding, grant codes and winner selection.
package cpu_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DATA    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE  = 2'b00;
  localparam logic [1:0] GRANT_FETCH = 2'b01;
  localparam logic [1:0] GRANT_DATA  = 2'b10;

  // Returns 1 when the load/store port should win the bus this cycle.
  // Under contention, round-robin hands the bus to whichever port did not
  // have it last; fixed priority always favours the data port.
  function automatic logic pick_data(input logic fetch_req,
                                     input logic data_req,
                                     input logic round_robin,
                                     input logic last_was_data);
    if (!fetch_req) return data_req;
    if (!data_req)  return 1'b0;
    return round_robin ? !last_was_data : 1'b1;
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single downstream CPU bus.
// One transaction at a time: grant, bus cycle, ready pulse, release.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_fetch_request,
  input  logic [31:0] i_fetch_address,
  output logic        o_fetch_ready,
  output logic [31:0] o_fetch_rdata,
  input  logic        i_data_request,
  input  logic        i_data_rw,
  input  logic [31:0] i_data_address,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_ready,
  output logic [31:0] o_data_rdata,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  output logic [1:0]  o_grant
);

  arb_state_e state;
  logic       last_was_data;
  logic       win_data;
  logic       granted_req;

  assign win_data    = pick_data(i_fetch_request, i_data_request,
                                 ROUND_ROBIN != 0, last_was_data);
  // Release waits on the request of whichever port currently owns the bus.
  assign granted_req = (o_grant == GRANT_DATA) ? i_data_request : i_fetch_request;

  // Arbitration FSM with all bus and port outputs registered.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      last_was_data <= 1'b1;  // so fetch wins the first contention
      o_bus_request <= 1'b0;
      o_bus_rw      <= 1'b0;
      o_bus_address <= '0;
      o_bus_wdata   <= '0;
      o_fetch_ready <= 1'b0;
      o_fetch_rdata <= '0;
      o_data_ready  <= 1'b0;
      o_data_rdata  <= '0;
      o_grant       <= GRANT_NONE;
    end else begin
      o_fetch_ready <= 1'b0;
      o_data_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_fetch_request || i_data_request) begin
            o_bus_request <= 1'b1;
            if (win_data) begin
              o_bus_rw      <= i_data_rw;
              o_bus_address <= i_data_address;
              o_bus_wdata   <= i_data_wdata;
              o_grant       <= GRANT_DATA;
              last_was_data <= 1'b1;
              state         <= DATA;
            end else begin
              o_bus_rw      <= 1'b0;
              o_bus_address <= i_fetch_address;
              o_bus_wdata   <= '0;
              o_grant       <= GRANT_FETCH;
              last_was_data <= 1'b0;
              state         <= FETCH;
            end
          end
        end
        FETCH, DATA: begin
          // Bus fields stay put until the target completes; a requester
          // dropping its request here does not cancel the cycle.
          if (i_bus_ready) begin
            o_bus_request <= 1'b0;
            if (state == FETCH) begin
              o_fetch_rdata <= i_bus_rdata;
              o_fetch_ready <= 1'b1;
            end else begin
              o_data_rdata  <= i_bus_rdata;
              o_data_ready  <= 1'b1;
            end
            state <= RELEASE;
          end
        end
        RELEASE: begin
          // Holding here until the owner lets go prevents a second issue
          // of a request still high through its ready cycle.
          if (!granted_req) begin
            o_grant <= GRANT_NONE;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: round-robin instance plus a
// fixed-priority instance for the data-first case.
module tb_cpu_bus_arbiter;
  import cpu_bus_arbiter_pkg::*;

  logic        i_clock, i_reset;
  logic        i_fetch_request, i_data_request, i_data_rw, i_bus_ready;
  logic [31:0] i_fetch_address, i_data_address, i_data_wdata, i_bus_rdata;
  logic        o_fetch_ready, o_data_ready, o_bus_request, o_bus_rw;
  logic [31:0] o_fetch_rdata, o_data_rdata, o_bus_address, o_bus_wdata;
  logic [1:0]  o_grant;

  logic        r0_fetch_request, r0_data_request, r0_bus_ready;
  logic        r0_fetch_ready, r0_data_ready, r0_bus_request, r0_bus_rw;
  logic [31:0] r0_fetch_rdata, r0_data_rdata, r0_bus_address, r0_bus_wdata;
  logic [1:0]  r0_grant;

  int n_checks = 0;
  int n_fail   = 0;
  int n_breq   = 0;
  int n_rdy    = 0;
  logic prev_breq = 1'b0;

  cpu_bus_arbiter #(.ROUND_ROBIN(1)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_fetch_request(i_fetch_request), .i_fetch_address(i_fetch_address),
    .o_fetch_ready(o_fetch_ready), .o_fetch_rdata(o_fetch_rdata),
    .i_data_request(i_data_request), .i_data_rw(i_data_rw),
    .i_data_address(i_data_address), .i_data_wdata(i_data_wdata),
    .o_data_ready(o_data_ready), .o_data_rdata(o_data_rdata),
    .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw),
    .o_bus_address(o_bus_address), .o_bus_wdata(o_bus_wdata),
    .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata), .o_grant(o_grant)
  );

  cpu_bus_arbiter #(.ROUND_ROBIN(0)) dut0 (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_fetch_request(r0_fetch_request), .i_fetch_address(32'h0000_0010),
    .o_fetch_ready(r0_fetch_ready), .o_fetch_rdata(r0_fetch_rdata),
    .i_data_request(r0_data_request), .i_data_rw(1'b0),
    .i_data_address(32'h0000_0020), .i_data_wdata(32'h0),
    .o_data_ready(r0_data_ready), .o_data_rdata(r0_data_rdata),
    .o_bus_request(r0_bus_request), .o_bus_rw(r0_bus_rw),
    .o_bus_address(r0_bus_address), .o_bus_wdata(r0_bus_wdata),
    .i_bus_ready(r0_bus_ready), .i_bus_rdata(32'h0000_00AB), .o_grant(r0_grant)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Count bus-request rising edges and ready pulses on the main instance.
  always @(posedge i_clock) begin
    prev_breq <= o_bus_request;
    if (o_bus_request === 1'b1 && prev_breq !== 1'b1) n_breq <= n_breq + 1;
    if (o_fetch_ready === 1'b1 || o_data_ready === 1'b1) n_rdy <= n_rdy + 1;
  end

  task automatic tick;
    @(posedge i_clock); #1;
  endtask

  task automatic do_reset;
    i_reset = 1'b1; tick; i_reset = 1'b0;
  endtask

  task automatic test_reset;
    i_reset = 1'b1; tick;
    n_checks++; if (o_bus_request !== 1'b0) begin n_fail++; $display("FAIL reset_breq got %b exp 0", o_bus_request); end
    n_checks++; if (o_grant !== GRANT_NONE) begin n_fail++; $display("FAIL reset_grant got %b exp 00", o_grant); end
    n_checks++; if ({o_fetch_ready, o_data_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b exp 00", {o_fetch_ready, o_data_ready}); end
    n_checks++; if ({o_fetch_rdata, o_data_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", {o_fetch_rdata, o_data_rdata}); end
    n_checks++; if ({o_bus_rw, o_bus_address, o_bus_wdata} !== 65'h0) begin n_fail++; $display("FAIL reset_bus got %h exp 0", {o_bus_rw, o_bus_address, o_bus_wdata}); end
    i_reset = 1'b0;
  endtask

  task automatic test_fetch_only;
    i_fetch_request = 1'b1; i_fetch_address = 32'h100; tick;
    n_checks++; if (o_grant !== GRANT_FETCH) begin n_fail++; $display("FAIL fetch_grant got %b exp 01", o_grant); end
    n_checks++; if ({o_bus_request, o_bus_rw} !== 2'b10) begin n_fail++; $display("FAIL fetch_req_rw got %b exp 10", {o_bus_request, o_bus_rw}); end
    n_checks++; if (o_bus_address !== 32'h100 || o_bus_wdata !== 32'h0) begin n_fail++; $display("FAIL fetch_bus got %h/%h exp 100/0", o_bus_address, o_bus_wdata); end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++; if (o_bus_request !== 1'b1 || o_fetch_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_wait%0d got req=%b rdy=%b exp 1/0", i, o_bus_request, o_fetch_ready); end
    end
    i_bus_ready = 1'b1; i_bus_rdata = 32'h13; tick; i_bus_ready = 1'b0;
    n_checks++; if (o_fetch_ready !== 1'b1 || o_fetch_rdata !== 32'h13) begin n_fail++; $display("FAIL fetch_done got rdy=%b rdata=%h exp 1/13", o_fetch_ready, o_fetch_rdata); end
    n_checks++; if (o_bus_request !== 1'b0 || o_data_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_done_bus got req=%b drdy=%b exp 0/0", o_bus_request, o_data_ready); end
    i_fetch_request = 1'b0; tick;
    n_checks++; if (o_fetch_ready !== 1'b0 || o_grant !== GRANT_NONE) begin n_fail++; $display("FAIL fetch_release got rdy=%b grant=%b exp 0/00", o_fetch_ready, o_grant); end
  endtask

  task automatic test_store_only;
    i_data_request = 1'b1; i_data_rw = 1'b1; i_data_address = 32'h2000; i_data_wdata = 32'hDEADBEEF; tick;
    n_checks++; if (o_grant !== GRANT_DATA || o_bus_rw !== 1'b1) begin n_fail++; $display("FAIL store_grant got %b rw=%b exp 10/1", o_grant, o_bus_rw); end
    n_checks++; if (o_bus_address !== 32'h2000 || o_bus_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_bus got %h/%h exp 2000/deadbeef", o_bus_address, o_bus_wdata); end
    i_bus_ready = 1'b1; i_bus_rdata = 32'h55; tick; i_bus_ready = 1'b0;
    n_checks++; if (o_data_ready !== 1'b1 || o_fetch_ready !== 1'b0) begin n_fail++; $display("FAIL store_ready got d=%b f=%b exp 1/0", o_data_ready, o_fetch_ready); end
    i_data_request = 1'b0; tick;
    n_checks++; if (o_data_ready !== 1'b0 || o_grant !== GRANT_NONE) begin n_fail++; $display("FAIL store_single got rdy=%b grant=%b exp 0/00", o_data_ready, o_grant); end
    n_checks++; if (o_fetch_rdata !== 32'h13 || o_data_rdata !== 32'h55) begin n_fail++; $display("FAIL rdata_hold got %h/%h exp 13/55", o_fetch_rdata, o_data_rdata); end
    i_data_rw = 1'b0;
  endtask

  task automatic test_hold;
    i_fetch_request = 1'b1; i_fetch_address = 32'h600; tick;
    i_bus_ready = 1'b1; i_bus_rdata = 32'h77; tick; i_bus_ready = 1'b0;
    n_checks++; if (o_fetch_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready got %b exp 1", o_fetch_ready); end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++; if (o_bus_request !== 1'b0 || o_fetch_ready !== 1'b0 || o_grant !== GRANT_FETCH) begin n_fail++; $display("FAIL hold%0d got req=%b rdy=%b grant=%b exp 0/0/01", i, o_bus_request, o_fetch_ready, o_grant); end
    end
    i_fetch_request = 1'b0; tick;
    n_checks++; if (o_grant !== GRANT_NONE) begin n_fail++; $display("FAIL hold_exit got %b exp 00", o_grant); end
    tick;
    n_checks++; if (o_bus_request !== 1'b0) begin n_fail++; $display("FAIL hold_reissue got %b exp 0", o_bus_request); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp;
    do_reset;
    i_fetch_address = 32'h1000; i_data_address = 32'h3000; i_data_rw = 1'b0;
    i_fetch_request = 1'b1; i_data_request = 1'b1;
    for (int r = 0; r < 4; r++) begin
      exp = (r % 2 == 0) ? GRANT_FETCH : GRANT_DATA;
      tick;
      n_checks++; if (o_grant !== exp) begin n_fail++; $display("FAIL rr_grant%0d got %b exp %b", r, o_grant, exp); end
      n_checks++; if (o_bus_address !== ((exp == GRANT_FETCH) ? 32'h1000 : 32'h3000)) begin n_fail++; $display("FAIL rr_addr%0d got %h", r, o_bus_address); end
      i_bus_ready = 1'b1; i_bus_rdata = 32'hC0 + r; tick; i_bus_ready = 1'b0;
      n_checks++; if ({o_fetch_ready, o_data_ready} !== ((exp == GRANT_FETCH) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_ready%0d got %b", r, {o_fetch_ready, o_data_ready}); end
      if (exp == GRANT_FETCH) i_fetch_request = 1'b0; else i_data_request = 1'b0;
      tick;
      if (exp == GRANT_FETCH) i_fetch_request = 1'b1; else i_data_request = 1'b1;
    end
    n_checks++; if (o_fetch_rdata !== 32'hC2 || o_data_rdata !== 32'hC3) begin n_fail++; $display("FAIL rr_rdata got %h/%h exp c2/c3", o_fetch_rdata, o_data_rdata); end
    i_fetch_request = 1'b0; i_data_request = 1'b0; tick;
  endtask

  task automatic test_fixed_priority;
    r0_fetch_request = 1'b1; r0_data_request = 1'b1;
    for (int r = 0; r < 2; r++) begin
      tick;
      n_checks++; if (r0_grant !== GRANT_DATA) begin n_fail++; $display("FAIL fp_grant%0d got %b exp 10", r, r0_grant); end
      r0_bus_ready = 1'b1; tick; r0_bus_ready = 1'b0;
      n_checks++; if ({r0_fetch_ready, r0_data_ready} !== 2'b01) begin n_fail++; $display("FAIL fp_ready%0d got %b exp 01", r, {r0_fetch_ready, r0_data_ready}); end
      r0_data_request = 1'b0; tick; r0_data_request = 1'b1;
    end
    r0_fetch_request = 1'b0; r0_data_request = 1'b0; tick;
  endtask

  task automatic test_reset_mid;
    i_data_request = 1'b1; i_data_rw = 1'b1; i_data_address = 32'h500; i_data_wdata = 32'h1; tick;
    n_checks++; if (o_bus_request !== 1'b1 || o_grant !== GRANT_DATA) begin n_fail++; $display("FAIL rmid_start got req=%b grant=%b exp 1/10", o_bus_request, o_grant); end
    tick;
    i_reset = 1'b1; i_data_request = 1'b0; tick;
    n_checks++; if (o_bus_request !== 1'b0 || o_grant !== GRANT_NONE || o_data_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_abort got req=%b grant=%b rdy=%b exp 0/00/0", o_bus_request, o_grant, o_data_ready); end
    i_reset = 1'b0; tick;
    n_checks++; if (o_data_ready !== 1'b0 || o_bus_request !== 1'b0 || o_bus_address !== 32'h0) begin n_fail++; $display("FAIL rmid_after got rdy=%b req=%b addr=%h exp 0/0/0", o_data_ready, o_bus_request, o_bus_address); end
    i_data_rw = 1'b0;
  endtask

  task automatic test_back_to_back;
    int b0, r0;
    b0 = n_breq; r0 = n_rdy;
    i_fetch_request = 1'b1; i_fetch_address = 32'h300; tick;
    i_data_request = 1'b1; i_data_rw = 1'b0; i_data_address = 32'h400; tick;
    n_checks++; if (o_grant !== GRANT_FETCH || o_bus_address !== 32'h300) begin n_fail++; $display("FAIL b2b_ignore got grant=%b addr=%h exp 01/300", o_grant, o_bus_address); end
    tick;
    i_bus_ready = 1'b1; i_bus_rdata = 32'hAAAA; tick; i_bus_ready = 1'b0;
    n_checks++; if ({o_fetch_ready, o_data_ready} !== 2'b10) begin n_fail++; $display("FAIL b2b_fready got %b exp 10", {o_fetch_ready, o_data_ready}); end
    i_fetch_request = 1'b0; tick;
    n_checks++; if (o_grant !== GRANT_NONE || o_bus_request !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got grant=%b req=%b exp 00/0", o_grant, o_bus_request); end
    tick;
    n_checks++; if (o_grant !== GRANT_DATA || o_bus_address !== 32'h400) begin n_fail++; $display("FAIL b2b_dgrant got grant=%b addr=%h exp 10/400", o_grant, o_bus_address); end
    i_bus_ready = 1'b1; i_bus_rdata = 32'hBBBB; tick; i_bus_ready = 1'b0;
    n_checks++; if (o_data_ready !== 1'b1 || o_data_rdata !== 32'hBBBB) begin n_fail++; $display("FAIL b2b_dready got rdy=%b rdata=%h exp 1/bbbb", o_data_ready, o_data_rdata); end
    i_data_request = 1'b0; tick; tick;
    n_checks++; if (n_breq - b0 !== 2 || n_rdy - r0 !== 2) begin n_fail++; $display("FAIL b2b_counts got breq=%0d rdy=%0d exp 2/2", n_breq - b0, n_rdy - r0); end
  endtask

  initial begin
    i_reset = 1'b0; i_fetch_request = 1'b0; i_data_request = 1'b0; i_data_rw = 1'b0;
    i_fetch_address = '0; i_data_address = '0; i_data_wdata = '0;
    i_bus_ready = 1'b0; i_bus_rdata = '0;
    r0_fetch_request = 1'b0; r0_data_request = 1'b0; r0_bus_ready = 1'b0;
    tick;
    test_reset;
    test_fetch_only;
    test_store_only;
    test_hold;
    test_round_robin;
    test_fixed_priority;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
